// File: rtl/gpio_pkg.sv
// Shared constants for the bidirectional GPIO controller: register map
// indices (addr[4:2]) and the common reset value.
package gpio_pkg;

  localparam int GPIO_REG_IDX_W = 3;
  typedef logic [GPIO_REG_IDX_W-1:0] gpio_reg_idx_t;

  localparam gpio_reg_idx_t GPIO_OFF_DATA_OUT   = 3'd0; // 0x00
  localparam gpio_reg_idx_t GPIO_OFF_DIR        = 3'd1; // 0x04
  localparam gpio_reg_idx_t GPIO_OFF_DATA_IN    = 3'd2; // 0x08
  localparam gpio_reg_idx_t GPIO_OFF_SET        = 3'd3; // 0x0C
  localparam gpio_reg_idx_t GPIO_OFF_CLR        = 3'd4; // 0x10
  localparam gpio_reg_idx_t GPIO_OFF_TOGGLE     = 3'd5; // 0x14
  localparam gpio_reg_idx_t GPIO_OFF_IRQ_EN     = 3'd6; // 0x18
  localparam gpio_reg_idx_t GPIO_OFF_IRQ_STATUS = 3'd7; // 0x1C

  localparam logic [31:0] GPIO_RST_VAL = 32'h0000_0000;

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchroniser for the asynchronous pad inputs; all stages
// clear to 0 on reset so no stale pin state survives a reset.
module gpio_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's old value and the chain really shifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= async_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign sync_o = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_bidir_ip.sv
// Memory-mapped bidirectional GPIO: per-pin direction, atomic SET/CLR/TOGGLE,
// synchronised inputs and masked rising-edge interrupts with W1C status.
module gpio_bidir_ip
  import gpio_pkg::*;
#(
  parameter int GPIO_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           addr,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic                  chip_select,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  localparam int WARM_CYCLES = SYNC_STAGES + 1;
  localparam int CNT_W       = $clog2(WARM_CYCLES + 1);

  logic [GPIO_WIDTH-1:0] data_out_q, data_out_d;
  logic [GPIO_WIDTH-1:0] dir_q, dir_d;
  logic [GPIO_WIDTH-1:0] irq_en_q, irq_en_d;
  logic [GPIO_WIDTH-1:0] irq_status_q, irq_status_d;
  logic [GPIO_WIDTH-1:0] prev_q;
  logic [GPIO_WIDTH-1:0] sync_val, wd, w1c, rise;
  logic [31:0]           read_data_q, read_data_d, rd_mux;
  logic [CNT_W-1:0]      warm_cnt_q, warm_cnt_d;
  logic                  warm_done, wr_en, rd_en;
  gpio_reg_idx_t         reg_idx;
  logic                  unused_addr_bits;

  assign reg_idx          = addr[4:2];
  assign unused_addr_bits = &{1'b0, addr[31:5], addr[1:0]};
  assign wr_en            = chip_select & write_enable;
  assign rd_en            = chip_select & read_enable;
  assign wd               = write_data[GPIO_WIDTH-1:0];

  gpio_sync #(
    .WIDTH  (GPIO_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (gpio_in),
    .sync_o  (sync_val)
  );

  // Edge detection stays off until the synchroniser and prev register hold
  // real pin data, so pins already high at reset release are not flagged.
  assign warm_done  = (warm_cnt_q == CNT_W'(WARM_CYCLES));
  assign warm_cnt_d = warm_done ? warm_cnt_q : warm_cnt_q + 1'b1;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irq_en_d   = irq_en_q;
    w1c        = '0;
    if (wr_en) begin
      case (reg_idx)
        GPIO_OFF_DATA_OUT:   data_out_d = wd;
        GPIO_OFF_DIR:        dir_d      = wd;
        GPIO_OFF_SET:        data_out_d = data_out_q | wd;
        GPIO_OFF_CLR:        data_out_d = data_out_q & ~wd;
        GPIO_OFF_TOGGLE:     data_out_d = data_out_q ^ wd;
        GPIO_OFF_IRQ_EN:     irq_en_d   = wd;
        GPIO_OFF_IRQ_STATUS: w1c        = wd;
        default: ;
      endcase
    end
    rise         = warm_done ? (sync_val & ~prev_q & ~dir_q & irq_en_q) : '0;
    // A new rise is OR-ed in after the clear, so it wins over a same-cycle W1C.
    irq_status_d = (irq_status_q & ~w1c) | rise;
  end

  always_comb begin
    rd_mux = GPIO_RST_VAL;
    case (reg_idx)
      GPIO_OFF_DATA_OUT:   rd_mux[GPIO_WIDTH-1:0] = data_out_q;
      GPIO_OFF_DIR:        rd_mux[GPIO_WIDTH-1:0] = dir_q;
      GPIO_OFF_DATA_IN:    rd_mux[GPIO_WIDTH-1:0] = sync_val;
      GPIO_OFF_IRQ_EN:     rd_mux[GPIO_WIDTH-1:0] = irq_en_q;
      GPIO_OFF_IRQ_STATUS: rd_mux[GPIO_WIDTH-1:0] = irq_status_q;
      default: ;
    endcase
    read_data_d = rd_en ? rd_mux : GPIO_RST_VAL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q   <= '0;
      dir_q        <= '0;
      irq_en_q     <= '0;
      irq_status_q <= '0;
      prev_q       <= '0;
      warm_cnt_q   <= '0;
      read_data_q  <= GPIO_RST_VAL;
    end else begin
      data_out_q   <= data_out_d;
      dir_q        <= dir_d;
      irq_en_q     <= irq_en_d;
      irq_status_q <= irq_status_d;
      prev_q       <= sync_val;
      warm_cnt_q   <= warm_cnt_d;
      read_data_q  <= read_data_d;
    end
  end

  assign read_data = read_data_q;
  assign gpio_out  = data_out_q;
  assign gpio_oe   = dir_q;
  assign irq       = |(irq_status_q & irq_en_q);

endmodule

// File: doc/gpio_bidir_ip.md
Name: gpio_bidir_ip

Overview:
Memory-mapped, parametrised bidirectional GPIO controller. It is the successor to the single-register output-only GPIO peripheral. It adds per-pin direction, atomic SET/CLR/TOGGLE writes, synchronised input sampling and rising-edge interrupts. It sits on the same simple chip-select/read/write peripheral bus and drives pad-level out/oe signals.

Parameters:
GPIO_WIDTH, 32, number of pins (1..32); bus bits above GPIO_WIDTH-1 ignored on write, read as 0.
SYNC_STAGES, 2, flip-flop depth of the input synchroniser (>=2).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
addr  input  32  byte address; addr[4:2] selects register, other bits ignored
write_data  input  32  write data
read_data  output  32  registered read data
write_enable  input  1  write strobe (qualified by chip_select)
read_enable  input  1  read strobe (qualified by chip_select)
chip_select  input  1  block select
gpio_in  input  GPIO_WIDTH  asynchronous pad inputs
gpio_out  output  GPIO_WIDTH  pad output values (= DATA_OUT)
gpio_oe  output  GPIO_WIDTH  pad output enables (= DIR, 1 = drive)
irq  output  1  level interrupt, OR of (IRQ_STATUS & IRQ_EN)

Behaviour:
- Register map (byte offsets): 0x00 DATA_OUT RW; 0x04 DIR RW; 0x08 DATA_IN RO (synchronised pins); 0x0C SET WO; 0x10 CLR WO; 0x14 TOGGLE WO; 0x18 IRQ_EN RW; 0x1C IRQ_STATUS RW1C.
- Reset (async assert, sync release): DATA_OUT, DIR, IRQ_EN, IRQ_STATUS, synchroniser, edge history, read_data all 0. Outputs: gpio_out=0, gpio_oe=0, irq=0.
- Write accepted when chip_select && write_enable at posedge clk. Effect is visible on gpio_out/gpio_oe in the cycle after that edge.
- SET: DATA_OUT |= wd. CLR: DATA_OUT &= ~wd. TOGGLE: DATA_OUT ^= wd.
- IRQ_STATUS write: each 1 bit clears that bit.
- Writes to the RO/WO-readback-0 offsets (DATA_IN) have no effect.
- Read accepted when chip_select && read_enable. read_data is registered and valid in the cycle after acceptance. In every other cycle read_data is 0.
- Read values: SET/CLR/TOGGLE read 0; all registers are zero-extended above GPIO_WIDTH.
- Simultaneous read and write to the same offset: read returns the pre-write value.
- Input path: gpio_in passes through SYNC_STAGES flops, so DATA_IN lags a pin change by SYNC_STAGES cycles. DATA_IN reflects pins regardless of DIR.
- Edge detect: prev register holds the last synchronised value. rise = sync & ~prev & ~DIR & IRQ_EN. Rising edges on output-mode pins are never flagged.
- IRQ_STATUS |= rise each cycle. Latency from pin edge to irq high is SYNC_STAGES+1 cycles.
- Same-cycle W1C and new rise on one bit: rise wins, bit stays 1.
- Clearing IRQ_EN does not clear IRQ_STATUS; it only masks irq.
- Warm-up: a counter blocks edge detection for SYNC_STAGES+1 cycles after reset release. A pin held high through reset therefore produces no interrupt. The counter saturates and then stays idle.
- Reset mid-operation: all state returns to reset values immediately; pending interrupts are lost; the warm-up restarts.

Decomposition:
- Package gpio_pkg: register offset constants (GPIO_OFF_DATA_OUT … GPIO_OFF_IRQ_STATUS), register index width, reset value constant.
- One sub-module, gpio_sync: a GPIO_WIDTH-wide, SYNC_STAGES-deep synchroniser with async reset to 0.
- Edge detect, register file and bus decode live in gpio_bidir_ip.

Test Plan:
- Reset then read all 8 offsets -> read_data 0 on each following cycle; gpio_out=0, gpio_oe=0, irq=0.
- Write DATA_OUT=0x0000_00F0, SET 0x3, CLR 0x10, TOGGLE 0x81 -> gpio_out steps F0, F3, E3, 62; read DATA_OUT returns 0x62.
- DIR=0xFFFF_0000, then pin 0 rises with IRQ_EN=0x1 -> IRQ_STATUS=0x1 and irq=1 exactly SYNC_STAGES+1 cycles after the edge. Pin 16 rising (output-mode) leaves status unchanged.
- With status=0x1: write IRQ_STATUS 0x1 in the same cycle as a new pin-0 rise -> status stays 0x1. A later W1C with no edge clears it and irq falls the next cycle.
- Hold gpio_in=0xFFFF_FFFF through reset with IRQ_EN=all ones written at the first opportunity -> no IRQ_STATUS bits set; DATA_IN reads 0xFFFF_FFFF.
- GPIO_WIDTH=8: write 0xDEAD_BEEF to DATA_OUT -> gpio_out=0xEF, read returns 0x0000_00EF. Assert rst mid-write -> gpio_out=0 asynchronously.
